// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
interface fetch_if;
  typedef struct packed {
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } fetch_decode;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  fetch_decode fd_reg;
  logic        fd_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr, fd_reg, fd_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr, fd_reg, fd_valid
  );
endinterface

// File: rtl/fetch.sv
// Dual-issue fetch stage: walks the PC, issues 8-byte line requests, buffers
// in-order responses with their PCs and presents instruction pairs to decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);
  localparam int          PW  = $clog2(QDEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [CW:0] CAP = (CW + 1)'(QDEPTH);

  logic [31:0]       pc_r;
  logic [31:0]       tag_pc_r [QDEPTH];
  logic [QDEPTH-1:0] tag_kill_r;
  logic [PW-1:0]     tag_wp_r;
  logic [PW-1:0]     tag_rp_r;
  logic [CW-1:0]     tag_cnt_r;
  logic [127:0]      buf_r [QDEPTH];
  logic [PW-1:0]     buf_wp_r;
  logic [PW-1:0]     buf_rp_r;
  logic [CW-1:0]     buf_cnt_r;

  logic [CW:0]   occ_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          tag_pop_s;
  logic          head_kill_s;
  logic          buf_push_s;
  logic          buf_pop_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   pc_next_s;
  logic [127:0]  entry_s;

  // Credit check, handshake strobes and the buffer entry built from a response.
  always_comb begin
    occ_s = {1'b0, tag_cnt_r} + {1'b0, buf_cnt_r};
    if (!reset && !bus.redirect_valid && (occ_s < CAP)) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    accept_s    = req_valid_s & bus.imem_req_ready;
    tag_pop_s   = bus.imem_resp_valid & (tag_cnt_r != {CW{1'b0}});
    head_pc_s   = tag_pc_r[tag_rp_r];
    // A same-cycle redirect kills the head being popped as well.
    head_kill_s = tag_kill_r[tag_rp_r] | bus.redirect_valid;
    buf_push_s  = tag_pop_s & ~head_kill_s;
    buf_pop_s   = ~bus.redirect_valid & ~bus.stall & (buf_cnt_r != {CW{1'b0}});
    if (pc_r[2]) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r + 32'd8;
    end
    if (head_pc_s[2]) begin
      entry_s = {bus.imem_resp_data[63:32], 32'h0000_0000, head_pc_s, head_pc_s + 32'd4};
    end else begin
      entry_s = {bus.imem_resp_data[31:0], bus.imem_resp_data[63:32], head_pc_s, head_pc_s + 32'd4};
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = {pc_r[31:3], 3'b000};

  // Program counter: redirect target, sequential advance on acceptance, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_r <= bus.redirect_pc;
    end else if (accept_s) begin
      pc_r <= pc_next_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Tag queue pointers, occupancy and kill flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wp_r   <= {PW{1'b0}};
      tag_rp_r   <= {PW{1'b0}};
      tag_cnt_r  <= {CW{1'b0}};
      tag_kill_r <= {QDEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        tag_wp_r <= tag_wp_r + PW'(1'b1);
      end
      if (tag_pop_s) begin
        tag_rp_r <= tag_rp_r + PW'(1'b1);
      end
      case ({accept_s, tag_pop_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + CW'(1'b1);
        2'b01:   tag_cnt_r <= tag_cnt_r - CW'(1'b1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
      if (bus.redirect_valid) begin
        tag_kill_r <= {QDEPTH{1'b1}};
      end else if (accept_s) begin
        tag_kill_r[tag_wp_r] <= 1'b0;
      end else begin
        tag_kill_r <= tag_kill_r;
      end
    end
  end

  // Response buffer pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_wp_r  <= {PW{1'b0}};
      buf_rp_r  <= {PW{1'b0}};
      buf_cnt_r <= {CW{1'b0}};
    end else if (bus.redirect_valid) begin
      buf_wp_r  <= {PW{1'b0}};
      buf_rp_r  <= {PW{1'b0}};
      buf_cnt_r <= {CW{1'b0}};
    end else begin
      if (buf_push_s) begin
        buf_wp_r <= buf_wp_r + PW'(1'b1);
      end
      if (buf_pop_s) begin
        buf_rp_r <= buf_rp_r + PW'(1'b1);
      end
      case ({buf_push_s, buf_pop_s})
        2'b10:   buf_cnt_r <= buf_cnt_r + CW'(1'b1);
        2'b01:   buf_cnt_r <= buf_cnt_r - CW'(1'b1);
        default: buf_cnt_r <= buf_cnt_r;
      endcase
    end
  end

  // Queue payload storage; occupancy counters decide which slots are live.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      tag_pc_r[tag_wp_r] <= pc_r;
    end
    if (buf_push_s) begin
      buf_r[buf_wp_r] <= entry_s;
    end
  end

  // Decode-facing pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.fd_reg   <= 128'h0;
      bus.fd_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      bus.fd_reg   <= 128'h0;
      bus.fd_valid <= 1'b0;
    end else if (bus.stall) begin
      bus.fd_reg   <= bus.fd_reg;
      bus.fd_valid <= bus.fd_valid;
    end else if (buf_pop_s) begin
      bus.fd_reg   <= buf_r[buf_rp_r];
      bus.fd_valid <= 1'b1;
    end else begin
      bus.fd_reg   <= 128'h0;
      bus.fd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: random memory latency, backpressure, stall and
// redirect, checked against a PC-level model of the expected pair stream.
module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;

  typedef struct packed {
    logic [31:0] ia;
    logic [31:0] ib;
    logic [31:0] pa;
    logic [31:0] pb;
  } pair_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pair_t       exp_q[$];
  mreq_t       mem_q[$];
  pair_t       mon_e;
  mreq_t       m;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] model_pc;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] first_acc_addr = 32'h0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          acc_cnt = 0;
  int          valid_cycles = 0;
  int          first_acc_cyc = -1;
  int          first_val_cyc = -1;
  int          redir_cyc = 0;
  int          redir_val_cyc = 0;
  bit          wrapped = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  // The pair decode should see for a fetch starting at program address p.
  function automatic pair_t expect_for(input logic [31:0] p);
    pair_t r;
    r.pa = p;
    r.pb = p + 32'd4;
    r.ia = word_at(p);
    r.ib = p[2] ? 32'h0 : word_at(p + 32'd4);
    return r;
  endfunction

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every pair consumed by decode must be the next expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fd_valid && !bus.stall && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pair: actual pc_a %h required no output", bus.fd_reg.pc_a);
        end else begin
          mon_e = exp_q.pop_front();
          check_w("pair", bus.fd_reg, mon_e);
        end
      end else if (!bus.fd_valid) begin
        check_w("idle_zero", bus.fd_reg, 128'h0);
      end
    end
  end

  // One cycle: observe at negedge, then drive memory response after the edge.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      if (bus.fd_valid) begin
        valid_cycles++;
        if (first_val_cyc < 0) first_val_cyc = cyc;
        if (redir_val_cyc < 0 && cyc > redir_cyc) redir_val_cyc = cyc;
      end
      if (bus.redirect_valid) check_i("no_req_in_redirect", int'(bus.imem_req_valid), 0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check_i("req_addr", int'(bus.imem_req_addr), int'({model_pc[31:3], 3'b000}));
        mem_q.push_back('{addr: bus.imem_req_addr,
                          due: cyc + int'($urandom_range(lat_hi, lat_lo))});
        exp_q.push_back(expect_for(model_pc));
        model_pc = {model_pc[31:3], 3'b000} + 32'd8;
        acc_cnt++;
        if (first_acc_cyc < 0) begin
          first_acc_cyc  = cyc;
          first_acc_addr = bus.imem_req_addr;
        end
        if (bus.imem_req_addr == 32'h0 && prev_addr == 32'hFFFF_FFF8) wrapped = 1'b1;
        prev_addr = bus.imem_req_addr;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        model_pc      = bus.redirect_pc;
        redir_cyc     = cyc;
        redir_val_cyc = -1;
      end
    end
    @(posedge clk);
    #1;
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 64'h0;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = {word_at(m.addr + 32'd4), word_at(m.addr)};
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_q.delete();
    exp_q.delete();
    model_pc            = RESET_PC;
    first_acc_cyc       = -1;
    first_val_cyc       = -1;
    bus.imem_resp_valid = 1'b0;
    #1;
    check_i("rst_fd_valid", int'(bus.fd_valid), 0);
    check_w("rst_fd_reg", bus.fd_reg, 128'h0);
    check_i("rst_req_valid", int'(bus.imem_req_valid), 0);
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    pair_t snap;
    logic  snap_v;
    int    a0;
    int    v0;
    bit    found;

    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 64'h0;
    model_pc           = RESET_PC;
    #1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Aligned stream with a 1-cycle memory.
    repeat (16) step();
    check_i("first_req_addr", int'(first_acc_addr), int'(RESET_PC));
    check_i("first_valid_latency", first_val_cyc - first_acc_cyc, 3);
    v0 = valid_cycles;
    repeat (10) step();
    check_i("throughput", valid_cycles - v0, 10);

    // Stall holds the output register.
    bus.stall = 1'b1;
    snap   = bus.fd_reg;
    snap_v = bus.fd_valid;
    check_i("stall_snap_valid", int'(snap_v), 1);
    repeat (10) begin
      step();
      check_w("stall_hold_reg", bus.fd_reg, snap);
      check_i("stall_hold_valid", int'(bus.fd_valid), int'(snap_v));
    end

    // Redirect during stall clears the output, then credit limits issue.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    check_i("redir_stall_clear", int'(bus.fd_valid), 0);
    a0 = acc_cnt;
    repeat (10) step();
    check_i("credit_accepts", acc_cnt - a0, QDEPTH);
    check_i("credit_req_off", int'(bus.imem_req_valid), 0);
    bus.stall = 1'b0;
    repeat (12) step();

    // Misaligned redirect and restart latency.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0104;
    step();
    repeat (10) step();
    check_i("redir_first_valid", redir_val_cyc - redir_cyc, 4);

    // 3-cycle memory: redirect with tags outstanding and a response arriving.
    lat_lo = 3;
    lat_hi = 3;
    repeat (10) step();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_resp_valid && mem_q.size() >= 2) found = 1'b1;
      else step();
    end
    check_i("inflight_window_found", int'(found), 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3000;
    step();
    repeat (20) step();

    // Reset mid-stream with requests outstanding.
    repeat (3) step();
    check_i("reset_tags_outstanding", int'(mem_q.size() > 0), 1);
    do_reset(2);
    repeat (10) step();
    check_i("post_reset_first_addr", int'(first_acc_addr), int'(RESET_PC));

    // Backpressure across the address wrap.
    lat_lo = 1;
    lat_hi = 3;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFE4;
    step();
    repeat (40) begin
      bus.imem_req_ready = 1'($urandom_range(1, 0));
      step();
    end
    check_i("addr_wrap_seen", int'(wrapped), 1);

    // Random mix of stall, backpressure, latency and redirects.
    for (int i = 0; i < 300; i++) begin
      bus.stall          = ($urandom_range(3, 0) == 0);
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(31, 0) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end

    // Drain: stop issuing and let every expected pair come out.
    bus.stall          = 1'b0;
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step();
    check_i("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
